// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports and one synchronous write port, with entry 0 hard-wired to zero.
// Defining REGFILE_BYPASS_EN forwards same-cycle write data straight to a read port whose address matches the write.
module register_file #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic             wr_ok;

  // Entry 0 is never written, so it keeps the zero it gets from reset.
  assign wr_ok = we && !reset && (waddr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Address 0 is masked on read as well, so it reads zero even before the first reset.
  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (waddr == raddr1)) rdata1 = wdata;
    if (wr_ok && (waddr == raddr2)) rdata2 = wdata;
`endif
  end

endmodule
